// File: rtl/fft_stream_framer_if.sv
// Bundle of every handshake, bus and status signal of the FFT framer except clock and reset.
// slave = framer view, master = environment (source, core and sink) view.
interface fft_stream_framer_if #(
    parameter int DATA_W = 8,
    parameter int EXP_W  = 6
);
    logic              in_valid, in_ready;
    logic [DATA_W-1:0] in_real, in_imag;
    logic              cfg_inverse, flush;

    logic [DATA_W-1:0] core_sink_real, core_sink_imag;
    logic              core_sink_valid, core_sink_sop, core_sink_eop, core_inverse;
    logic [1:0]        core_sink_error;
    logic              core_sink_ready;

    logic [DATA_W-1:0] core_source_real, core_source_imag;
    logic              core_source_valid, core_source_sop, core_source_eop;
    logic [EXP_W-1:0]  core_source_exp;
    logic [1:0]        core_source_error;
    logic              core_source_ready;

    logic [DATA_W-1:0] out_real, out_imag;
    logic              out_valid, out_sop, out_eop, out_ready;
    logic [EXP_W-1:0]  out_exp;
    logic [15:0]       frames_in, frames_out;
    logic              err_sticky;

    modport slave (
        input  in_valid, in_real, in_imag, cfg_inverse, flush, core_sink_ready,
               core_source_real, core_source_imag, core_source_valid, core_source_sop,
               core_source_eop, core_source_exp, core_source_error, out_ready,
        output in_ready, core_sink_real, core_sink_imag, core_sink_valid, core_sink_sop,
               core_sink_eop, core_inverse, core_sink_error, core_source_ready,
               out_real, out_imag, out_valid, out_sop, out_eop, out_exp,
               frames_in, frames_out, err_sticky
    );

    modport master (
        output in_valid, in_real, in_imag, cfg_inverse, flush, core_sink_ready,
               core_source_real, core_source_imag, core_source_valid, core_source_sop,
               core_source_eop, core_source_exp, core_source_error, out_ready,
        input  in_ready, core_sink_real, core_sink_imag, core_sink_valid, core_sink_sop,
               core_sink_eop, core_inverse, core_sink_error, core_source_ready,
               out_real, out_imag, out_valid, out_sop, out_eop, out_exp,
               frames_in, frames_out, err_sticky
    );
endinterface

// File: rtl/fft_stream_framer.sv
// Streaming FFT framer: input FIFO, N-point framing with flush zero-padding toward the core,
// and pass-through of core results with exponent hold, framing check and frame counters.
module fft_stream_framer #(
    parameter int DATA_W    = 8,
    parameter int LEN_LOG2  = 10,
    parameter int FIFO_LOG2 = 4,
    parameter int EXP_W     = 6
) (
    input logic clk,
    input logic reset,
    fft_stream_framer_if.slave bus
);
    localparam int N  = 1 << LEN_LOG2;
    localparam int D  = 1 << FIFO_LOG2;
    localparam int IW = (LEN_LOG2 > 0) ? LEN_LOG2 : 1;
    localparam int AW = (FIFO_LOG2 > 0) ? FIFO_LOG2 : 1;
    localparam int CW = FIFO_LOG2 + 1;

    typedef struct packed {
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
    } sample_t;

    typedef enum logic [1:0] {IDLE, STREAM, PAD} state_t;

    sample_t          mem [D];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    state_t           state;
    logic [IW-1:0]    idx, out_idx;
    logic             inverse_q;
    logic [15:0]      frames_in_q, frames_out_q;
    logic [EXP_W-1:0] out_exp_q;
    logic             err_q;

    logic    in_ready, push, pop, sink_valid, sink_eop, xfer, acc, frame_err;
    sample_t head;

    // ---------------- sink side ----------------
    assign in_ready   = (count < CW'(D)) && (state != PAD);
    assign push       = bus.in_valid && in_ready && !bus.flush;
    assign sink_valid = (state == PAD) || (count != '0);
    assign sink_eop   = (idx == IW'(N - 1));
    assign xfer       = sink_valid && bus.core_sink_ready;
    assign pop        = xfer && (state != PAD);
    assign head       = (state == PAD) ? '0 : mem[rd_ptr];

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(D - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{re: bus.in_real, im: bus.in_imag};
    end

    // Flush wins over push/pop; a flush in PAD finds the FIFO already empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // A flush that lands while a frame is open (including on its SOP beat) pads it out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            inverse_q   <= 1'b0;
            frames_in_q <= '0;
        end else if (xfer) begin
            if (state == IDLE) inverse_q <= bus.cfg_inverse;
            if (sink_eop) begin
                idx         <= '0;
                frames_in_q <= frames_in_q + 16'd1;
                state       <= IDLE;
            end else begin
                idx   <= idx + 1'b1;
                state <= (bus.flush || state == PAD) ? PAD : STREAM;
            end
        end else if (bus.flush && state == STREAM) begin
            state <= PAD;
        end
    end

    assign bus.in_ready        = in_ready;
    assign bus.core_sink_valid = sink_valid;
    assign bus.core_sink_sop   = (state == IDLE);
    assign bus.core_sink_eop   = sink_eop;
    assign bus.core_sink_real  = head.re;
    assign bus.core_sink_imag  = head.im;
    assign bus.core_inverse    = inverse_q;
    assign bus.core_sink_error = 2'b00;

    // ---------------- source side ----------------
    assign acc = bus.core_source_valid && bus.out_ready;
    assign frame_err = acc && ((bus.core_source_sop && out_idx != '0) ||
                               (!bus.core_source_sop && out_idx == '0) ||
                               (bus.core_source_eop && out_idx != IW'(N - 1)));

    // An unexpected SOP resynchronises the beat index to the new frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_idx      <= '0;
            out_exp_q    <= '0;
            frames_out_q <= '0;
            err_q        <= 1'b0;
        end else begin
            if (acc) begin
                if (bus.core_source_sop) out_exp_q <= bus.core_source_exp;
                if (bus.core_source_eop) begin
                    out_idx      <= '0;
                    frames_out_q <= frames_out_q + 16'd1;
                end else if (bus.core_source_sop) begin
                    out_idx <= IW'(1);
                end else begin
                    out_idx <= out_idx + 1'b1;
                end
            end
            if (frame_err || (bus.core_source_valid && bus.core_source_error != 2'b00))
                err_q <= 1'b1;
        end
    end

    assign bus.out_real          = bus.core_source_real;
    assign bus.out_imag          = bus.core_source_imag;
    assign bus.out_valid         = bus.core_source_valid;
    assign bus.out_sop           = bus.core_source_sop;
    assign bus.out_eop           = bus.core_source_eop;
    assign bus.core_source_ready = bus.out_ready;
    assign bus.out_exp           = out_exp_q;
    assign bus.frames_in         = frames_in_q;
    assign bus.frames_out        = frames_out_q;
    assign bus.err_sticky        = err_q;
endmodule

// File: tb/tb_fft_stream_framer.sv
// Bench for fft_stream_framer with N = 8, D = 4: a scoreboard of expected core-side beats
// plus per-scenario tasks for flush, backpressure, exponent hold and output framing.
module tb_fft_stream_framer;
    localparam int N = 8;

    typedef struct packed {
        logic [7:0] re;
        logic [7:0] im;
    } smp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fft_stream_framer_if #(.DATA_W(8), .EXP_W(6)) bus ();

    fft_stream_framer #(.DATA_W(8), .LEN_LOG2(3), .FIFO_LOG2(2), .EXP_W(6)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int   checks = 0, fails = 0;
    smp_t sbq[$];
    int   m_beat = 0, m_frames = 0;
    bit   m_pad = 0, m_inv = 0;
    int   exp_fin = 0, exp_fout = 0;
    bit   tog = 0;

    // Core-side monitor: every sink transfer is checked against the scoreboard and beat model.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.core_sink_valid && bus.core_sink_ready) begin
                smp_t e;
                e = '0;
                if (!m_pad) begin
                    if (sbq.size() == 0) begin
                        checks++; fails++;
                        $display("FAIL sink_underflow: beat %0d transferred, no sample expected", m_beat);
                    end else e = sbq.pop_front();
                end
                checks++;
                if ({bus.core_sink_real, bus.core_sink_imag} !== e) begin
                    fails++;
                    $display("FAIL sink_data beat %0d: got %h/%h want %h/%h", m_beat,
                             bus.core_sink_real, bus.core_sink_imag, e.re, e.im);
                end
                checks++;
                if (bus.core_sink_sop !== (m_beat == 0) || bus.core_sink_eop !== (m_beat == N - 1)) begin
                    fails++;
                    $display("FAIL sink_framing beat %0d: got sop=%b eop=%b", m_beat,
                             bus.core_sink_sop, bus.core_sink_eop);
                end
                if (m_beat != 0) begin
                    checks++;
                    if (bus.core_inverse !== m_inv) begin
                        fails++;
                        $display("FAIL sink_inverse beat %0d: got %b want %b", m_beat, bus.core_inverse, m_inv);
                    end
                end else m_inv = bus.cfg_inverse;
                if (m_beat == N - 1) begin
                    m_beat = 0; m_pad = 0; m_frames++;
                end else m_beat++;
            end
            if (bus.flush && !m_pad) begin
                sbq.delete();
                if (m_beat != 0) m_pad = 1;
            end
            if (bus.in_valid && bus.in_ready && !bus.flush)
                sbq.push_back('{re: bus.in_real, im: bus.in_imag});
        end
    end

    task automatic send(input logic [7:0] re, input logic [7:0] im);
        int n = 0;
        bus.in_real = re; bus.in_imag = im; bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            checks++; fails++;
            $display("FAIL send_timeout: in_ready stayed %b", bus.in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (m_frames < target && n < 500) begin @(posedge clk); n++; end
        #1;
        checks++;
        if (m_frames < target) begin
            fails++;
            $display("FAIL frame_timeout: got %0d frames want %0d", m_frames, target);
        end
    endtask

    task automatic drv_src(input bit sop, input bit eop, input logic [5:0] e,
                           input logic [7:0] d, input bit toggle);
        int n = 0;
        bit done = 0;
        bus.core_source_valid = 1'b1; bus.core_source_sop = sop; bus.core_source_eop = eop;
        bus.core_source_exp = e; bus.core_source_real = d; bus.core_source_imag = ~d;
        while (!done && n < 50) begin
            if (toggle) begin bus.out_ready = tog; tog = ~tog; end
            @(negedge clk);
            checks++;
            if (bus.core_source_ready !== bus.out_ready) begin
                fails++;
                $display("FAIL src_ready: got %b want %b", bus.core_source_ready, bus.out_ready);
            end
            if (bus.out_ready) begin
                done = 1;
                checks++;
                if (bus.out_real !== d || bus.out_imag !== ~d || bus.out_valid !== 1'b1 ||
                    bus.out_sop !== sop || bus.out_eop !== eop) begin
                    fails++;
                    $display("FAIL out_pass: got %h/%h v%b s%b e%b want %h/%h v1 s%b e%b",
                             bus.out_real, bus.out_imag, bus.out_valid, bus.out_sop, bus.out_eop,
                             d, ~d, sop, eop);
                end
            end
            @(posedge clk); #1;
            n++;
        end
        if (!done) begin
            checks++; fails++;
            $display("FAIL src_timeout: beat d=%h never accepted", d);
        end
        bus.core_source_valid = 1'b0;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (bus.in_ready !== 1'b1) begin checks++; fails++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end else checks++;
        if (bus.core_sink_valid !== 1'b0) begin checks++; fails++; $display("FAIL rst_sink_valid: got %b want 0", bus.core_sink_valid); end else checks++;
        if (bus.frames_in !== 16'd0 || bus.frames_out !== 16'd0) begin
            checks++; fails++; $display("FAIL rst_frames: got %0d/%0d want 0/0", bus.frames_in, bus.frames_out);
        end else checks++;
        if (bus.err_sticky !== 1'b0 || bus.out_exp !== 6'd0 || bus.core_inverse !== 1'b0 || bus.core_sink_error !== 2'b00) begin
            checks++; fails++;
            $display("FAIL rst_flags: got err=%b exp=%h inv=%b serr=%b want 0", bus.err_sticky, bus.out_exp, bus.core_inverse, bus.core_sink_error);
        end else checks++;
        @(posedge clk); #1;
        reset = 1'b0;
        sbq.delete(); m_beat = 0; m_pad = 0; m_frames = 0; exp_fin = 0; exp_fout = 0;
    endtask

    task automatic test_continuous;
        bus.core_sink_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(8'(i + 1), 8'(8'h80 + i));
        bus.in_valid = 1'b0;
        wait_frames(2);
        exp_fin += 2;
        chk("cont_frames_in", bus.frames_in, 16'(exp_fin));
        chk("cont_drained", {15'd0, bus.core_sink_valid}, 16'd0);
    endtask

    task automatic test_inverse;
        bus.cfg_inverse = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(8'(8'h20 + i), 8'(i));
            if (i == 2) bus.cfg_inverse = 1'b1;
        end
        bus.in_valid = 1'b0;
        wait_frames(m_frames + 1 - (m_beat == 0 ? 0 : 0));
        chk("inv_first_frame", {15'd0, bus.core_inverse}, 16'd0);
        for (int i = 0; i < 8; i++) begin
            send(8'(8'h30 + i), 8'(i));
            if (i == 2) bus.cfg_inverse = 1'b0;
        end
        bus.in_valid = 1'b0;
        wait_frames(m_frames + 1);
        chk("inv_second_frame", {15'd0, bus.core_inverse}, 16'd1);
        exp_fin += 2;
        chk("inv_frames_in", bus.frames_in, 16'(exp_fin));
    endtask

    task automatic test_backpressure;
        int n_acc = 0;
        int target = m_frames + 1;
        bus.core_sink_ready = 1'b0;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus.in_real = 8'(8'h40 + n_acc); bus.in_imag = 8'(8'hc0 + n_acc);
            @(negedge clk);
            if (bus.in_ready) n_acc++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        chk("bp_accepts", 16'(n_acc), 16'd4);
        chk("bp_in_ready_low", {15'd0, bus.in_ready}, 16'd0);
        bus.core_sink_ready = 1'b1;
        for (int i = 4; i < 8; i++) send(8'(8'h40 + i), 8'(8'hc0 + i));
        bus.in_valid = 1'b0;
        wait_frames(target);
        exp_fin += 1;
        chk("bp_frames_in", bus.frames_in, 16'(exp_fin));
    endtask

    task automatic test_flush;
        int target = m_frames + 1;
        bus.core_sink_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'(8'h50 + i), 8'(8'h50 + i));
        bus.in_valid = 1'b0;
        bus.core_sink_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.core_sink_ready = 1'b0;
        chk("flush_beats_before", 16'(m_beat), 16'd3);
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_real = 8'h7f; bus.in_imag = 8'h7f;
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        chk("flush_pad_in_ready", {15'd0, bus.in_ready}, 16'd0);
        chk("flush_pad_valid", {15'd0, bus.core_sink_valid}, 16'd1);
        bus.core_sink_ready = 1'b1;
        wait_frames(target);
        exp_fin += 1;
        chk("flush_frames_in", bus.frames_in, 16'(exp_fin));
        chk("flush_fifo_empty", {14'd0, bus.core_sink_valid, bus.in_ready}, 16'd1);
    endtask

    task automatic test_out_clean;
        bus.out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            drv_src(i == 0, i == N - 1, (i == 0) ? 6'h05 : 6'h07, 8'(8'h60 + i), 1'b0);
            chk("exp_hold", 16'(bus.out_exp), 16'h05);
        end
        exp_fout += 1;
        chk("clean_frames_out", bus.frames_out, 16'(exp_fout));
        chk("clean_no_err", {15'd0, bus.err_sticky}, 16'd0);
    endtask

    task automatic test_out_toggle;
        tog = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < N; i++)
                drv_src(i == 0, i == N - 1, (i == 0) ? 6'h03 : 6'h11, 8'(8'h70 + i), 1'b1);
            exp_fout += 1;
            chk("toggle_frames_out", bus.frames_out, 16'(exp_fout));
        end
        chk("toggle_exp", 16'(bus.out_exp), 16'h03);
        chk("toggle_no_err", {15'd0, bus.err_sticky}, 16'd0);
        bus.out_ready = 1'b1;
    endtask

    task automatic test_out_err;
        for (int i = 0; i < 3; i++) drv_src(i == 0, 1'b0, (i == 0) ? 6'h05 : 6'h09, 8'(8'h90 + i), 1'b0);
        chk("err_exp_held", 16'(bus.out_exp), 16'h05);
        chk("err_before_bad_sop", {15'd0, bus.err_sticky}, 16'd0);
        drv_src(1'b1, 1'b0, 6'h05, 8'h93, 1'b0);
        chk("err_bad_sop", {15'd0, bus.err_sticky}, 16'd1);
        chk("err_exp_after", 16'(bus.out_exp), 16'h05);
    endtask

    task automatic test_core_error;
        test_reset;
        chk("cerr_cleared", {15'd0, bus.err_sticky}, 16'd0);
        bus.out_ready = 1'b0;
        bus.core_source_valid = 1'b1; bus.core_source_sop = 1'b1; bus.core_source_error = 2'b10;
        @(posedge clk); #1;
        bus.core_source_valid = 1'b0; bus.core_source_error = 2'b00;
        chk("cerr_sticky", {15'd0, bus.err_sticky}, 16'd1);
        chk("cerr_no_frame", bus.frames_out, 16'd0);
    endtask

    initial begin
        bus.in_valid = 0; bus.in_real = 0; bus.in_imag = 0; bus.cfg_inverse = 0; bus.flush = 0;
        bus.core_sink_ready = 0; bus.core_source_real = 0; bus.core_source_imag = 0;
        bus.core_source_valid = 0; bus.core_source_sop = 0; bus.core_source_eop = 0;
        bus.core_source_exp = 0; bus.core_source_error = 0; bus.out_ready = 0;
        test_reset;
        test_continuous;
        test_inverse;
        test_backpressure;
        test_flush;
        test_out_clean;
        test_out_toggle;
        test_out_err;
        test_core_error;
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
